qeciphy_tx_arbiter: RTL



---
 rtl/qeciphy_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/qeciphy_tx_arbiter.sv
// Round-robin arbiter that shares the QECIPHY TX AXI-Stream between NUM_REQ requesters, gated on link-ready.
// Latency: grant one edge after a request seen in IDLE; S_*->M_* data and M_TREADY->S_TREADY are combinational (zero added latency).
// Backpressure: M_TREADY passes straight to the granted S_TREADY only; a pending beat stays presented until it handshakes.
module qeciphy_tx_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         DATA_WIDTH   = 64,
    parameter int         MAX_BURST    = 16,
    parameter logic [3:0] LINK_UP_CODE = 4'b0100
) (
    input  logic                          ACLK,
    input  logic                          ARSTn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] S_TDATA,
    input  logic [NUM_REQ-1:0]            S_TVALID,
    output logic [NUM_REQ-1:0]            S_TREADY,
    output logic [DATA_WIDTH-1:0]         M_TDATA,
    output logic                          M_TVALID,
    input  logic                          M_TREADY,
    input  logic [3:0]                    STATUS,
    output logic [NUM_REQ-1:0]            GRANT,
    output logic                          BUSY
);

    localparam int         PTR_W     = $clog2(NUM_REQ);
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NUM_REQ-1:0] grant_q;
    // Index of the most recent winner; doubles as the granted index while in GRANT.
    logic [PTR_W-1:0]   last_ptr_q;
    logic [7:0]         beat_cnt_q;

    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [PTR_W:0]     cand;
    logic               link_up;
    logic               g_vld;
    logic               accept;
    logic               release_grant;

    assign link_up = (STATUS == LINK_UP_CODE);
    assign g_vld   = S_TVALID[last_ptr_q];
    assign accept  = (state_q == ST_GRANT) && g_vld && M_TREADY;

    // Release: burst limit reached on an accepted beat, the owner went idle,
    // or the link dropped once no beat is left pending.
    assign release_grant = (accept && (beat_cnt_q == LAST_BEAT))
                         || !g_vld
                         || (!link_up && (!g_vld || accept));

    // Rotating search: first valid requester starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_ptr_q;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && S_TVALID[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Zero-latency datapath: route the granted requester to the PHY, quiet when idle.
    always_comb begin
        M_TDATA  = '0;
        M_TVALID = 1'b0;
        S_TREADY = '0;
        if (state_q == ST_GRANT) begin
            M_TDATA            = S_TDATA[last_ptr_q*DATA_WIDTH +: DATA_WIDTH];
            M_TVALID           = g_vld;
            S_TREADY[last_ptr_q] = M_TREADY;
        end
    end

    // Next-state: grant only with link up and a requester waiting; leave on any release condition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (link_up && win_found) state_d = ST_GRANT;
            ST_GRANT: if (release_grant)        state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant vector, round-robin pointer and burst beat counter.
    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            grant_q    <= '0;
            last_ptr_q <= PTR_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (link_up && win_found) begin
                grant_q    <= NUM_REQ'(1) << win_idx;
                last_ptr_q <= win_idx;
                beat_cnt_q <= '0;
            end
        end else begin
            if (accept) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if (release_grant) begin
                grant_q <= '0;
            end
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = (state_q == ST_GRANT);

endmodule
